div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_if.sv | 21 ++
 rtl/div_ctrl.sv | 127 ++++++++++++
 tb/tb_div_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EXE stage (master) and the iterative divider (slave).
interface div_ctrl_if;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic        stallreq_exe;
    logic        div_ready;
    logic [63:0] div_result;

    modport master (
        output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        input  stallreq_exe, div_ready, div_result
    );

    modport slave (
        input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        output stallreq_exe, div_ready, div_result
    );
endinterface

// File: rtl/div_ctrl.sv
// 32-bit restoring divider (DIV/DIVU): 34 edges to div_ready, 2 on divide-by-zero.
// Holds the pipeline via stallreq_exe until div_ready; result held in END while div_start stays high.
module div_ctrl (
    input  logic      cpu_clk_50M,
    input  logic      cpu_rst,
    div_ctrl_if.slave div_bus
);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [64:0] part, part_nxt;      // [64:32] partial remainder, [31:0] quotient
    logic [31:0] divisor, divisor_nxt;
    logic        neg_quo, neg_quo_nxt;
    logic        neg_rem, neg_rem_nxt;
    logic        ready_q, ready_nxt;
    logic [63:0] result_q, result_nxt;

    logic        accept;
    logic [31:0] abs_op1, abs_op2;
    logic [64:0] shifted;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign accept  = div_bus.div_start & ~div_bus.div_annul;
    assign abs_op1 = (div_bus.div_signed & div_bus.div_opdata1[31]) ?
                     (~div_bus.div_opdata1 + 32'd1) : div_bus.div_opdata1;
    assign abs_op2 = (div_bus.div_signed & div_bus.div_opdata2[31]) ?
                     (~div_bus.div_opdata2 + 32'd1) : div_bus.div_opdata2;

    assign shifted = part << 1;
    assign trial   = {1'b0, shifted[64:32]} - {2'b00, divisor};
    assign quo_fix = neg_quo ? (~part[31:0] + 32'd1) : part[31:0];
    assign rem_fix = neg_rem ? (~part[63:32] + 32'd1) : part[63:32];

    assign div_bus.div_ready    = ready_q;
    assign div_bus.div_result   = result_q;
    assign div_bus.stallreq_exe = div_bus.div_start & ~ready_q & ~div_bus.div_annul;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            part     <= 65'd0;
            divisor  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            part     <= part_nxt;
            divisor  <= divisor_nxt;
            neg_quo  <= neg_quo_nxt;
            neg_rem  <= neg_rem_nxt;
            ready_q  <= ready_nxt;
            result_q <= result_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (div_bus.div_opdata2 == 32'd0) ? BYZERO : ON;
            BYZERO:  state_nxt = div_bus.div_annul ? IDLE : END;
            ON: begin
                if (div_bus.div_annul)  state_nxt = IDLE;
                else if (cnt == 6'd32)  state_nxt = END;
            end
            END:     if (div_bus.div_annul || !div_bus.div_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt     = cnt;
        part_nxt    = part;
        divisor_nxt = divisor;
        neg_quo_nxt = neg_quo;
        neg_rem_nxt = neg_rem;
        ready_nxt   = ready_q;
        result_nxt  = result_q;
        unique case (state)
            IDLE: begin
                ready_nxt  = 1'b0;
                result_nxt = 64'd0;
                if (accept && div_bus.div_opdata2 != 32'd0) begin
                    cnt_nxt     = 6'd0;
                    part_nxt    = {33'd0, abs_op1};
                    divisor_nxt = abs_op2;
                    neg_quo_nxt = div_bus.div_signed & (div_bus.div_opdata1[31] ^ div_bus.div_opdata2[31]);
                    neg_rem_nxt = div_bus.div_signed & div_bus.div_opdata1[31];
                end
            end
            BYZERO: begin
                cnt_nxt    = 6'd0;
                ready_nxt  = ~div_bus.div_annul;
                result_nxt = 64'd0;
            end
            ON: begin
                if (div_bus.div_annul) begin
                    cnt_nxt    = 6'd0;
                    ready_nxt  = 1'b0;
                    result_nxt = 64'd0;
                end else if (cnt == 6'd32) begin
                    ready_nxt  = 1'b1;
                    result_nxt = {rem_fix, quo_fix};
                end else begin
                    // A borrow out of the trial subtraction means the step restores.
                    part_nxt = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};
                    cnt_nxt  = cnt + 6'd1;
                end
            end
            END: begin
                if (div_bus.div_annul || !div_bus.div_start) begin
                    ready_nxt  = 1'b0;
                    result_nxt = 64'd0;
                end
            end
            default: begin
                ready_nxt  = 1'b0;
                result_nxt = 64'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide-by-zero, annul and async reset.
module tb_div_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   edges;

    div_ctrl_if bus ();

    div_ctrl dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .div_bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.div_signed  = sgn;
        bus.div_opdata1 = a;
        bus.div_opdata2 = b;
        bus.div_annul   = 1'b0;
        bus.div_start   = 1'b1;
    endtask

    task automatic wait_ready(input int max_edges, output int seen);
        seen = -1;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (bus.div_ready === 1'b1) begin
                seen = i;
                return;
            end
        end
    endtask

    task automatic release_op();
        bus.div_start = 1'b0;
        bus.div_annul = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.div_start = 1'b0; bus.div_signed = 1'b0; bus.div_annul = 1'b0;
        bus.div_opdata1 = 32'd0; bus.div_opdata2 = 32'd0;
        tick(); tick();
        n_cmp++; if (bus.div_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.div_ready); end
        n_cmp++; if (bus.div_result !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.div_result); end
        n_cmp++; if (bus.stallreq_exe !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.stallreq_exe); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_100_7();
        set_op(1'b0, 32'd100, 32'd7);
        #1;
        n_cmp++; if (bus.stallreq_exe !== 1'b1) begin n_bad++; $display("FAIL stall_comb: got %b want 1", bus.stallreq_exe); end
        for (int e = 1; e <= 33; e++) begin
            tick();
            n_cmp++;
            if (bus.stallreq_exe !== 1'b1 || bus.div_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_edge%0d: stall=%b ready=%b want 1/0", e, bus.stallreq_exe, bus.div_ready);
            end
        end
        tick();
        n_cmp++; if (bus.div_ready !== 1'b1) begin n_bad++; $display("FAIL u100_7_ready_e34: got %b want 1", bus.div_ready); end
        n_cmp++; if (bus.div_result !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL u100_7_result: got %h want %h", bus.div_result, {32'd2, 32'd14}); end
        n_cmp++; if (bus.stallreq_exe !== 1'b0) begin n_bad++; $display("FAIL u100_7_stall_done: got %b want 0", bus.stallreq_exe); end
        tick();
        n_cmp++; if (bus.div_ready !== 1'b1 || bus.div_result !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL end_hold: ready=%b result=%h want 1/%h", bus.div_ready, bus.div_result, {32'd2, 32'd14}); end
        release_op();
        n_cmp++; if (bus.div_ready !== 1'b0 || bus.div_result !== 64'd0) begin n_bad++; $display("FAIL end_release: ready=%b result=%h want 0/0", bus.div_ready, bus.div_result); end
    endtask

    task automatic test_signed();
        set_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_ready(40, edges);
        n_cmp++; if (edges !== 34) begin n_bad++; $display("FAIL s_neg7_2_latency: got %0d want 34", edges); end
        n_cmp++; if (bus.div_result !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL s_neg7_2_result: got %h want ffffffff_fffffffd", bus.div_result); end
        release_op();
        set_op(1'b0, 32'hFFFF_FFFF, 32'd2);
        wait_ready(40, edges);
        n_cmp++; if (bus.div_result !== 64'h0000_0001_7FFF_FFFF) begin n_bad++; $display("FAIL u_max_2_result: got %h want 00000001_7fffffff", bus.div_result); end
        release_op();
        set_op(1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_ready(40, edges);
        n_cmp++; if (bus.div_result !== 64'hFFFF_FFFF_0000_0000) begin n_bad++; $display("FAIL s_m1_2_result: got %h want ffffffff_00000000", bus.div_result); end
        release_op();
        set_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(40, edges);
        n_cmp++; if (bus.div_result !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL s_overflow_result: got %h want 00000000_80000000", bus.div_result); end
        release_op();
    endtask

    task automatic test_div_by_zero();
        set_op(1'b0, 32'h1234_5678, 32'd0);
        wait_ready(40, edges);
        n_cmp++; if (edges !== 2) begin n_bad++; $display("FAIL byzero_latency: got %0d want 2", edges); end
        n_cmp++; if (bus.div_result !== 64'd0) begin n_bad++; $display("FAIL byzero_result: got %h want 0", bus.div_result); end
        release_op();
    endtask

    task automatic test_operand_change();
        set_op(1'b0, 32'd1000, 32'd3);
        tick();
        bus.div_opdata1 = 32'hDEAD_BEEF;
        bus.div_opdata2 = 32'd0;
        bus.div_signed  = 1'b1;
        wait_ready(40, edges);
        n_cmp++; if (edges !== 33) begin n_bad++; $display("FAIL opchg_latency: got %0d more edges want 33", edges); end
        n_cmp++; if (bus.div_result !== {32'd1, 32'd333}) begin n_bad++; $display("FAIL opchg_result: got %h want %h", bus.div_result, {32'd1, 32'd333}); end
        release_op();
    endtask

    task automatic test_annul();
        logic saw_ready;
        set_op(1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        bus.div_annul = 1'b1;
        #1;
        n_cmp++; if (bus.stallreq_exe !== 1'b0) begin n_bad++; $display("FAIL annul_stall: got %b want 0", bus.stallreq_exe); end
        tick();
        bus.div_annul = 1'b0;
        bus.div_start = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_ready !== 1'b0) saw_ready = 1'b1;
            tick();
        end
        n_cmp++; if (saw_ready !== 1'b0) begin n_bad++; $display("FAIL annul_on_pulse: ready pulsed=%b want 0", saw_ready); end
        set_op(1'b0, 32'd100, 32'd7);
        wait_ready(40, edges);
        n_cmp++; if (edges !== 34 || bus.div_result !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL annul_restart: edges=%0d result=%h want 34/%h", edges, bus.div_result, {32'd2, 32'd14}); end
        release_op();
        set_op(1'b0, 32'd5, 32'd0);
        tick();
        bus.div_annul = 1'b1;
        tick();
        bus.div_annul = 1'b0;
        bus.div_start = 1'b0;
        n_cmp++; if (bus.div_ready !== 1'b0) begin n_bad++; $display("FAIL annul_byzero: ready=%b want 0", bus.div_ready); end
        tick();
        set_op(1'b0, 32'd5, 32'd0);
        wait_ready(10, edges);
        bus.div_annul = 1'b1;
        tick();
        n_cmp++; if (bus.div_ready !== 1'b0 || bus.div_result !== 64'd0) begin n_bad++; $display("FAIL annul_end: edges=%0d ready=%b result=%h want 0/0", edges, bus.div_ready, bus.div_result); end
        release_op();
    endtask

    task automatic test_async_reset();
        set_op(1'b0, 32'd100, 32'd7);
        repeat (19) tick();
        #2;
        rst = 1'b1;
        bus.div_start = 1'b0;
        #1;
        n_cmp++; if (bus.div_ready !== 1'b0 || bus.div_result !== 64'd0 || bus.stallreq_exe !== 1'b0) begin n_bad++; $display("FAIL rst_mid_op: ready=%b result=%h stall=%b want 0", bus.div_ready, bus.div_result, bus.stallreq_exe); end
        #2;
        rst = 1'b0;
        tick();
        set_op(1'b0, 32'd9, 32'd4);
        wait_ready(40, edges);
        #2;
        rst = 1'b1;
        bus.div_start = 1'b0;
        #1;
        n_cmp++; if (bus.div_ready !== 1'b0 || bus.div_result !== 64'd0) begin n_bad++; $display("FAIL rst_async_end: edges=%0d ready=%b result=%h want 0/0", edges, bus.div_ready, bus.div_result); end
        #2;
        rst = 1'b0;
        tick();
        set_op(1'b0, 32'd100, 32'd7);
        wait_ready(40, edges);
        n_cmp++; if (edges !== 34 || bus.div_result !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL rst_fresh_op: edges=%0d result=%h want 34/%h", edges, bus.div_result, {32'd2, 32'd14}); end
        release_op();
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, 32'd50, 32'd5);
        wait_ready(40, edges);
        n_cmp++; if (bus.div_result !== {32'd0, 32'd10}) begin n_bad++; $display("FAIL b2b_first: got %h want %h", bus.div_result, {32'd0, 32'd10}); end
        release_op();
        set_op(1'b0, 32'd9, 32'd4);
        wait_ready(40, edges);
        n_cmp++; if (edges !== 34 || bus.div_result !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL b2b_second: edges=%0d result=%h want 34/%h", edges, bus.div_result, {32'd1, 32'd2}); end
        release_op();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_unsigned_100_7();
        test_signed();
        test_div_by_zero();
        test_operand_change();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
